// File: rtl/data_mem_responder.sv
// data_mem_responder: data memory with host preload, processor access and dump.
// Optional dump stream is built when macro DM_DUMP_EN is defined.
module data_mem_responder #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] ar_in,
    input  logic        dm_en,
    input  logic [16:0] bus_in,
    input  logic        end_process,
    output logic [11:0] dm_out,
    input  logic        load_valid,
    input  logic        load_last,
    input  logic [11:0] load_addr,
    input  logic [11:0] load_data,
    output logic        load_ready,
    output logic        dump_valid,
    output logic [11:0] dump_addr,
    output logic [11:0] dump_data,
    input  logic        dump_ready,
    output logic        dump_done,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [12:0] LIMIT = 13'(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [11:0]        dm_out_q, dm_out_d;
    logic               ep_q;
    logic               ep_rise;
    logic               we;
    logic [AW-1:0]      waddr;
    logic [DATA_W-1:0]  wdata;
    logic               ar_ok;
    logic               ld_ok;
    logic [DATA_W-1:0]  ar_rd;
    logic               unused_ok;

    // Out-of-range addresses never touch the array and read as zero.
    assign ar_ok   = ({1'b0, ar_in} < LIMIT);
    assign ld_ok   = ({1'b0, load_addr} < LIMIT);
    assign ar_rd   = ar_ok ? mem[ar_in[AW-1:0]] : '0;
    assign ep_rise = end_process & ~ep_q;

`ifdef DM_DUMP_EN
    localparam logic [11:0] LAST_ADDR = 12'(DEPTH - 1);

    logic              dv_q, dv_d;
    logic [11:0]       da_q, da_d;
    logic [DATA_W-1:0] dd_q, dd_d;
    logic [11:0]       da_next;
    logic [DATA_W-1:0] dump_rd;

    assign da_next = da_q + 12'd1;
    assign dump_rd = mem[da_next[AW-1:0]];
    assign unused_ok = ^bus_in[16:12];
`else
    assign unused_ok = ^{bus_in[16:12], dump_ready};
`endif

    // Next state, write port selection, read capture and dump beat advance.
    always_comb begin
        state_d  = state_q;
        dm_out_d = dm_out_q;
        we       = 1'b0;
        waddr    = ar_in[AW-1:0];
        wdata    = DATA_W'(bus_in[11:0]);
`ifdef DM_DUMP_EN
        dv_d     = dv_q;
        da_d     = da_q;
        dd_d     = dd_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                if (load_valid) begin
                    we    = ld_ok;
                    waddr = load_addr[AW-1:0];
                    wdata = DATA_W'(load_data);
                    if (load_last) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                we       = dm_en & ar_ok;
                dm_out_d = 12'(ar_rd);
                if (ep_rise) begin
`ifdef DM_DUMP_EN
                    state_d = S_DUMP;
                    dv_d    = 1'b1;
                    da_d    = '0;
                    dd_d    = mem[0];
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_DUMP: begin
`ifdef DM_DUMP_EN
                if (dv_q && dump_ready) begin
                    if (da_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        dv_d    = 1'b0;
                    end else begin
                        da_d = da_next;
                        dd_d = dump_rd;
                    end
                end
`endif
            end
            S_DONE: begin
            end
        endcase
    end

    // Control state, registered read data and end_process history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_LOAD;
            dm_out_q <= '0;
            ep_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dm_out_q <= dm_out_d;
            ep_q     <= end_process;
        end
    end

    // Storage is deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef DM_DUMP_EN
    // Dump beat registers, held steady while the host stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q <= 1'b0;
            da_q <= '0;
            dd_q <= '0;
        end else begin
            dv_q <= dv_d;
            da_q <= da_d;
            dd_q <= dd_d;
        end
    end

    assign dump_valid = dv_q;
    assign dump_addr  = da_q;
    assign dump_data  = 12'(dd_q);
`else
    assign dump_valid = 1'b0;
    assign dump_addr  = '0;
    assign dump_data  = '0;
`endif

    assign dm_out     = dm_out_q;
    assign load_ready = (state_q == S_LOAD);
    assign busy       = (state_q == S_RUN) || (state_q == S_DUMP);
    assign dump_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized bench with a behavioural memory model.
// Dump-stream checks are compiled in when DM_DUMP_EN is defined.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] ar_in = '0;
    logic        dm_en = 1'b0;
    logic [16:0] bus_in = '0;
    logic        end_process = 1'b0;
    logic [11:0] dm_out;
    logic        load_valid = 1'b0;
    logic        load_last = 1'b0;
    logic [11:0] load_addr = '0;
    logic [11:0] load_data = '0;
    logic        load_ready;
    logic        dump_valid;
    logic [11:0] dump_addr;
    logic [11:0] dump_data;
    logic        dump_ready = 1'b0;
    logic        dump_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH(DEPTH), .DATA_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .ar_in(ar_in), .dm_en(dm_en),
        .bus_in(bus_in), .end_process(end_process), .dm_out(dm_out),
        .load_valid(load_valid), .load_last(load_last),
        .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .dump_valid(dump_valid),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_ready(dump_ready), .dump_done(dump_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {P_LOAD, P_RUN, P_DUMP, P_DONE} ph_t;
    ph_t         ph = P_LOAD;
    logic [11:0] mmem [DEPTH];
    logic [11:0] exp_dm = '0;
    bit          ep_prev = 1'b0;
    int          nxt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = P_LOAD;
            exp_dm = '0;
            ep_prev = 1'b0;
            nxt = 0;
        end else begin
            case (ph)
                P_LOAD: if (load_valid) begin
                    if (load_addr < DEPTH) mmem[load_addr] = load_data;
                    if (load_last) ph = P_RUN;
                end
                P_RUN: begin
                    exp_dm = (ar_in < DEPTH) ? mmem[ar_in] : 12'h000;
                    if (dm_en && ar_in < DEPTH) mmem[ar_in] = bus_in[11:0];
                    if (end_process && !ep_prev) begin
`ifdef DM_DUMP_EN
                        ph = P_DUMP;
                        nxt = 0;
`else
                        ph = P_DONE;
`endif
                    end
                end
                P_DUMP: if (dump_valid && dump_ready) begin
                    if (nxt == DEPTH - 1) ph = P_DONE;
                    else nxt++;
                end
                default: ;
            endcase
            ep_prev = end_process;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          pv = 1'b0;
    logic [11:0] paddr = '0;
    logic [11:0] pdata = '0;
    int          gap = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(ph == P_RUN || ph == P_DUMP));
            check("load_ready", 32'(load_ready), 32'(ph == P_LOAD));
            check("dump_done", 32'(dump_done), 32'(ph == P_DONE));
            check("dm_out", 32'(dm_out), 32'(exp_dm));
`ifdef DM_DUMP_EN
            if (ph == P_DUMP) begin
                if (pv && !dump_ready) begin
                    check("hold_valid", 32'(dump_valid), 32'd1);
                    check("hold_addr", 32'(dump_addr), 32'(paddr));
                    check("hold_data", 32'(dump_data), 32'(pdata));
                end
                if (dump_valid) begin
                    gap = 0;
                    check("dump_addr", 32'(dump_addr), 32'(nxt));
                    check("dump_data", 32'(dump_data), 32'(mmem[nxt]));
                end else begin
                    gap++;
                    check("dump_gap_ok", 32'(gap <= 2), 32'd1);
                end
            end else begin
                gap = 0;
                check("dump_valid_idle", 32'(dump_valid), 32'd0);
            end
`else
            check("dump_valid_off", 32'(dump_valid), 32'd0);
            check("dump_addr_off", 32'(dump_addr), 32'd0);
            check("dump_data_off", 32'(dump_data), 32'd0);
`endif
            pv = dump_valid;
            paddr = dump_addr;
            pdata = dump_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_dm_out"}, 32'(dm_out), 32'd0);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
        check({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
        check({tag, "_dump_addr"}, 32'(dump_addr), 32'd0);
        check({tag, "_dump_data"}, 32'(dump_data), 32'd0);
        check({tag, "_dump_done"}, 32'(dump_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_random(input int n, input bit ep);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) != 0) begin
                if ($urandom_range(7) == 0)
                    ar_in = 12'($urandom_range(DEPTH, 4095));
                else
                    ar_in = 12'($urandom_range(0, DEPTH - 1));
            end
            dm_en = 1'($urandom);
            bus_in = 17'($urandom);
            load_valid = 1'($urandom);
            load_last = 1'($urandom);
            load_addr = 12'($urandom_range(0, DEPTH - 1));
            load_data = 12'($urandom);
            end_process = ep;
            step();
        end
        dm_en = 1'b0;
        load_valid = 1'b0;
        load_last = 1'b0;
    endtask

    task automatic enter_run(input bit ep);
        load_valid = 1'b1;
        load_last = 1'b1;
        load_addr = 12'hFFF;
        load_data = 12'($urandom);
        end_process = ep;
        step();
        load_valid = 1'b0;
        load_last = 1'b0;
        check("enter_run_busy", 32'(busy), 32'd1);
    endtask

`ifdef DM_DUMP_EN
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
`endif

    initial begin
        #1 rst_n = 1'b0;
        #1 reset_check("por");
        step();
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            if (a == 7) continue;
            if ($urandom_range(3) == 0) begin
                load_valid = 1'b0;
                step();
            end
            load_valid = 1'b1;
            load_last = 1'b0;
            load_addr = 12'(a);
            load_data = (a == 5) ? 12'h0AB : (a == 9) ? 12'h777 : 12'($urandom);
            ar_in = 12'($urandom);
            dm_en = 1'($urandom);
            bus_in = 17'($urandom);
            step();
            if ($urandom_range(7) == 0) begin
                load_addr = 12'($urandom_range(DEPTH, 4095));
                load_data = 12'($urandom);
                step();
            end
        end
        load_valid = 1'b0;
        dm_en = 1'b0;
        step();
        check("load_ready_in_load", 32'(load_ready), 32'd1);
        check("busy_in_load", 32'(busy), 32'd0);

        load_valid = 1'b1;
        load_last = 1'b1;
        load_addr = 12'd7;
        load_data = 12'h123;
        step();
        load_valid = 1'b0;
        load_last = 1'b0;
        check("run_after_last", 32'(busy), 32'd1);
        check("load_ready_run", 32'(load_ready), 32'd0);

        ar_in = 12'd5;
        step();
        check("read5", 32'(dm_out), 32'h0AB);

        ar_in = 12'd9;
        dm_en = 1'b1;
        bus_in = 17'h1F456;
        step();
        check("read9_old", 32'(dm_out), 32'h777);
        dm_en = 1'b0;
        step();
        check("read9_new", 32'(dm_out), 32'h456);

        ar_in = 12'h800;
        dm_en = 1'b1;
        bus_in = 17'h00ABC;
        step();
        check("read800_wr", 32'(dm_out), 32'd0);
        dm_en = 1'b0;
        step();
        check("read800", 32'(dm_out), 32'd0);

        run_random(300, 1'b0);

`ifdef DM_DUMP_EN
        begin
            bit hit = 1'b0;
            end_process = 1'b1;
            for (int k = 0; k < 600 && !hit; k++) begin
                dump_ready = pat[k % 4];
                step();
                hit = dump_valid && (dump_addr == 12'd40);
            end
            check("reach_addr40", 32'(hit), 32'd1);
            rst_n = 1'b0;
            #1 reset_check("mid_dump");
            step();
            rst_n = 1'b1;
            dump_ready = 1'b0;
        end

        enter_run(1'b1);
        run_random(100, 1'b1);
        check("ep_high_no_dump", 32'(busy), 32'd1);
        end_process = 1'b0;
        step();
        end_process = 1'b1;
        step();
        check("dump_busy", 32'(busy), 32'd1);
        begin
            bit fin = 1'b0;
            for (int k = 0; k < 3000 && !fin; k++) begin
                dump_ready = pat[k % 4];
                step();
                fin = dump_done;
            end
            check("dump_finished", 32'(fin), 32'd1);
            check("dump_last_idx", 32'(nxt), 32'(DEPTH - 1));
        end
`else
        rst_n = 1'b0;
        #1 reset_check("mid_run");
        step();
        rst_n = 1'b1;

        enter_run(1'b0);
        run_random(100, 1'b0);
        end_process = 1'b1;
        step();
        check("done_after_ep", 32'(dump_done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
`endif

        run_random(20, 1'b1);
        check("done_held", 32'(dump_done), 32'd1);
        check("done_dump_valid", 32'(dump_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

endmodule
